// File: rtl/seg7_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | seg7_scan_ctrl : N-digit multiplexed 7-segment scanner, tear-free updates  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50,
  parameter int BLANK_CYC  = 1,
  parameter int IDX_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [7:0]              number,
  output logic                    frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_pend;
  logic [4*NUM_DIGITS-1:0] r_val_pend, r_val_act;
  logic [NUM_DIGITS-1:0]   r_dp_pend, r_dp_act;
  logic [NUM_DIGITS-1:0]   r_blank_pend, r_blank_act;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic [7:0]              r_number;
  logic                    r_frame_start;

  logic                    w_tick, w_wrap, w_ghost;
  logic                    w_all_zero;
  logic [NUM_DIGITS-1:0]   w_lz_dark;
  logic [NUM_DIGITS-1:0]   w_dig_sel;
  logic [3:0]              w_cur_val;
  logic                    w_cur_dp, w_cur_dark;
  logic [NUM_DIGITS-1:0]   w_dig_nxt;
  logic [7:0]              w_num_nxt;

  function automatic logic [6:0] f_seg(input logic [3:0] v);
    case (v)
      4'h0: f_seg = 7'b1111110;
      4'h1: f_seg = 7'b0110000;
      4'h2: f_seg = 7'b1101101;
      4'h3: f_seg = 7'b1111001;
      4'h4: f_seg = 7'b0110011;
      4'h5: f_seg = 7'b1011011;
      4'h6: f_seg = 7'b1011111;
      4'h7: f_seg = 7'b1110000;
      4'h8: f_seg = 7'b1111111;
      4'h9: f_seg = 7'b1111011;
      4'hA: f_seg = 7'b1110111;
      4'hB: f_seg = 7'b0011111;
      4'hC: f_seg = 7'b1001110;
      4'hD: f_seg = 7'b0111101;
      4'hE: f_seg = 7'b1001111;
      default: f_seg = 7'b1000111;
    endcase
  endfunction

  assign w_tick = (r_cnt == C_CNT_MAX);
  assign w_wrap = w_tick && (r_idx == C_IDX_MAX);

  generate
    if (BLANK_CYC > 0) begin : g_ghost_cmp
      assign w_ghost = (r_cnt < CNT_W'(BLANK_CYC));
    end else begin : g_ghost_none
      assign w_ghost = 1'b0;
    end
  endgenerate

  always_comb begin
    w_all_zero = 1'b1;
    w_lz_dark  = '0;
    // Scan from the most significant digit down; a digit is a leading zero
    // while every digit at or above it is zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_all_zero   = w_all_zero & (r_val_act[4*i +: 4] == 4'h0);
      w_lz_dark[i] = lz_en & w_all_zero & (i != 0);
    end

    w_dig_sel  = '1;
    w_cur_val  = 4'h0;
    w_cur_dp   = 1'b0;
    w_cur_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_dig_sel[i] = 1'b0;
        w_cur_val    = r_val_act[4*i +: 4];
        w_cur_dp     = r_dp_act[i];
        w_cur_dark   = r_blank_act[i] | w_lz_dark[i];
      end
    end

    w_dig_nxt = '1;
    w_num_nxt = 8'h00;
    if (!w_ghost) begin
      w_dig_nxt = w_dig_sel;
      if (!w_cur_dark) begin
        w_num_nxt = {f_seg(w_cur_val), w_cur_dp};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pend        <= 1'b0;
      r_val_pend    <= '0;
      r_dp_pend     <= '0;
      r_blank_pend  <= '0;
      r_val_act     <= '0;
      r_dp_act      <= '0;
      r_blank_act   <= '0;
      r_dig         <= '1;
      r_number      <= 8'h00;
      r_frame_start <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_wrap && r_pend) begin
        r_val_act   <= r_val_pend;
        r_dp_act    <= r_dp_pend;
        r_blank_act <= r_blank_pend;
      end

      // A load on the wrap edge wins: the old pending set commits above and
      // the new one stays pending for the next frame.
      if (load) begin
        r_val_pend   <= val_in;
        r_dp_pend    <= dp_in;
        r_blank_pend <= blank_in;
        r_pend       <= 1'b1;
      end else if (w_wrap) begin
        r_pend <= 1'b0;
      end

      r_dig         <= w_dig_nxt;
      r_number      <= w_num_nxt;
      r_frame_start <= w_wrap;
    end
  end

  assign dig         = r_dig;
  assign number      = r_number;
  assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_seg7_scan_ctrl : directed self-checking bench for seg7_scan_ctrl        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] val_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic [3:0]  dig;
  logic [7:0]  number;
  logic        frame_start;

  int n_pass  = 0;
  int n_total = 0;

  // Hand-derived {abcdefg,dp} codes
  localparam logic [7:0] C_N0 = 8'hFC;
  localparam logic [7:0] C_N1 = 8'h60;
  localparam logic [7:0] C_N2 = 8'hDA;
  localparam logic [7:0] C_N3 = 8'hF2;
  localparam logic [7:0] C_N4 = 8'h66;
  localparam logic [7:0] C_N5 = 8'hB6;
  localparam logic [7:0] C_NA = 8'hEE;
  localparam logic [7:0] C_NB = 8'h3E;
  localparam logic [7:0] C_NC_DP = 8'h9D;
  localparam logic [7:0] C_ND = 8'h7A;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (4),
    .BLANK_CYC (1),
    .IDX_W     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .val_in     (val_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .dig        (dig),
    .number     (number),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One 4-cycle slot: ghost cycle, then three cycles lighting digit s.
  task automatic check_slot(input string tag, input int s, input logic [3:0] exp_dig,
                            input logic [7:0] exp_num);
    step();
    load = 1'b0;
    chk($sformatf("%s s%0d ghost dig", tag, s), {4'h0, dig}, 8'h0F);
    chk($sformatf("%s s%0d ghost num", tag, s), number, 8'h00);
    chk($sformatf("%s s%0d ghost fs", tag, s), {7'h0, frame_start}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("%s s%0d dig", tag, s), {4'h0, dig}, {4'h0, exp_dig});
      chk($sformatf("%s s%0d num", tag, s), number, exp_num);
    end
  endtask

  // Full frame; exp packs per-digit number codes {d3,d2,d1,d0}.
  task automatic check_frame(input string tag, input logic [31:0] exp);
    logic [3:0] sel;
    for (int s = 0; s < 4; s++) begin
      sel = 4'b0001 << s;
      check_slot(tag, s, ~sel, exp[8*s +: 8]);
    end
    chk({tag, " frame_start"}, {7'h0, frame_start}, 8'h01);
  endtask

  initial begin
    bit found;
    rst = 1'b1; load = 1'b0; val_in = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
    step();
    step();
    chk("reset dig", {4'h0, dig}, 8'h0F);
    chk("reset num", number, 8'h00);
    chk("reset fs", {7'h0, frame_start}, 8'h00);

    // Reset & scan: load 1234, nothing shows until the first wrap
    rst = 1'b0; load = 1'b1; val_in = 16'h1234; dp_in = 4'b0000;
    step();
    load = 1'b0;
    chk("pre ghost dig", {4'h0, dig}, 8'h0F);
    step();
    chk("pre commit dig", {4'h0, dig}, 8'h0E);
    chk("pre commit num", number, C_N0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (frame_start === 1'b1) found = 1'b1;
    end
    chk("first frame_start seen", {7'h0, found}, 8'h01);
    check_frame("scan1234", {C_N1, C_N2, C_N3, C_N4});

    // Tear-free: mid-frame load of ABCD keeps 1234 for this frame
    check_slot("tear", 0, 4'b1110, C_N4);
    load = 1'b1; val_in = 16'hABCD; dp_in = 4'b0010;
    check_slot("tear", 1, 4'b1101, C_N3);
    check_slot("tear", 2, 4'b1011, C_N2);
    check_slot("tear", 3, 4'b0111, C_N1);
    chk("tear frame_start", {7'h0, frame_start}, 8'h01);
    dp_in = 4'b0000;
    check_frame("abcd", {C_NA, C_NB, C_NC_DP, C_ND});

    // Load on the wrap-tick cycle
    load = 1'b1; val_in = 16'h1111;
    step();
    load = 1'b0;
    for (int k = 0; k < 14; k++) step();
    load = 1'b1; val_in = 16'h2222;
    step();
    load = 1'b0;
    chk("wrapload frame_start", {7'h0, frame_start}, 8'h01);
    check_frame("wrap1111", {C_N1, C_N1, C_N1, C_N1});
    lz_en = 1'b1;
    load = 1'b1; val_in = 16'h0050;
    check_frame("wrap2222", {C_N2, C_N2, C_N2, C_N2});

    // Leading-zero suppression
    load = 1'b1; val_in = 16'h0000;
    check_frame("lz0050", {8'h00, 8'h00, C_N5, C_N0});
    load = 1'b1; val_in = 16'h1234; blank_in = 4'b0100;
    check_frame("lz0000", {8'h00, 8'h00, 8'h00, C_N0});

    // Explicit blanking, then reset mid-frame with a pending load
    lz_en = 1'b0;
    check_frame("blank", {C_N1, 8'h00, C_N3, C_N4});
    load = 1'b1; val_in = 16'hFFFF; blank_in = 4'b0000;
    check_slot("rstmid", 0, 4'b1110, C_N4);
    check_slot("rstmid", 1, 4'b1101, C_N3);
    rst = 1'b1;
    step();
    chk("rstmid dig", {4'h0, dig}, 8'h0F);
    chk("rstmid num", number, 8'h00);
    rst = 1'b0;
    check_frame("post rst", {C_N0, C_N0, C_N0, C_N0});
    check_frame("no commit", {C_N0, C_N0, C_N0, C_N0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment display driver for the board-level display path. Generalises the fixed 3-digit scanner to N digits.
- Features: per-digit hex input, per-digit decimal point, explicit blanking, optional leading-zero suppression, inter-digit ghost blanking.
- Tear-free update: new display values are captured on a load strobe and committed only at a frame boundary.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal 1..8).
- SCAN_DIV, 50, clk cycles per digit slot (legal >= 2).
- BLANK_CYC, 1, cycles at the start of each slot with all digit selects inactive (legal 0..SCAN_DIV-1).
- IDX_W, 3, scan index width (must satisfy 2^IDX_W >= NUM_DIGITS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- load  in  1  single-cycle strobe; captures val_in, dp_in, blank_in
- val_in  in  4*NUM_DIGITS  hex value per digit; digit i = val_in[4i+3:4i]
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_in  in  NUM_DIGITS  1 = force digit i dark
- lz_en  in  1  leading-zero suppression enable (live, not shadowed)
- dig  out  NUM_DIGITS  digit select, active-low; dig[i] drives digit i
- number  out  8  {a,b,c,d,e,f,g,dp}, active-high; number[7] = a, number[0] = dp
- frame_start  out  1  one-cycle pulse when scan index wraps to 0

Behaviour:
- Reset (rst=1 at posedge):
  - Prescaler cnt <= 0; scan idx <= 0; pend <= 0.
  - Pending and active value/dp/blank registers <= 0.
  - Outputs: dig <= all 1s (all off), number <= 8'h00, frame_start <= 0.
  - Reset mid-frame discards any pending load.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1.
  - tick = (cnt == SCAN_DIV-1); on tick, cnt <= 0.
- Scan index:
  - On tick, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - When NUM_DIGITS = 1, idx stays 0 and every tick is a wrap.
- Load / commit:
  - load=1 captures inputs into the pending registers and sets pend <= 1; a later load overwrites pending.
  - On a wrap tick (idx N-1 -> 0) with pend=1: active <= pending (pre-edge value) and pend <= 0.
  - load coinciding with a wrap tick: the old pending value is committed, the new value is captured, and pend stays 1 (new value commits at the next wrap).
- Leading-zero suppression (lz_en=1):
  - Digit i is dark if active value of every digit j >= i is 0, for i >= 1.
  - Digit 0 is never LZ-blanked.
  - A DP on a suppressed digit is also suppressed.
- Output stage (registered, 1-cycle latency from state (idx, cnt)):
  - Slot ghost-blank: if cnt < BLANK_CYC, dig = all 1s and number = 0.
  - Digit dark (blank_in or LZ): dig[idx] = 0 and number = 0.
  - Otherwise: dig = ~(1 << idx) and number = {seg(active[idx]), dp[idx]}.
  - frame_start registered: 1 in the cycle after a wrap tick.
- Segment table abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Exactly one dig bit is low at most at any time; none while rst is asserted.
- Frame period = NUM_DIGITS*SCAN_DIV clk cycles.

Test Plan:
- Bench parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
- Reset & scan: rst 2 cycles, then load val_in=16'h1234, dp_in=0 -> after first wrap, each slot shows dig=1110/number=8'b01100110 (4 on digit 0), then 1101/"3", 1011/"2", 0111/"1"; first cycle of each slot dig=1111, number=0; frame_start pulses every 16 cycles.
- Tear-free load: load 16'h1234 committed, then mid-frame load 16'hABCD with dp_in=4'b0010 -> remaining slots of the current frame still show 1234; next frame shows D,C(+dp, number[0]=1),B,A.
- Load on wrap tick: pend holds 16'h1111, then load 16'h2222 on the wrap-tick cycle -> next frame shows 1111, following frame shows 2222.
- LZ suppression: lz_en=1, value 16'h0050 -> digits 3 and 2 dark (dig bit low, number=0), digits 1/0 show 5/0; value 16'h0000 -> only digit 0 shows 0.
- Blank & reset mid-frame: blank_in=4'b0100 -> digit 2 slot number=0; assert rst during slot 2 with a pending load -> next cycle dig=1111, number=0; after release no commit occurs, active value stays 0, scan restarts at digit 0.
